// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM state type, bus widths and slave indices.
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;
  localparam int REQ_ADDR_W = 9;

  localparam logic SLV1 = 1'b0;
  localparam logic SLV2 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Loadable ACCESS wait-state counter; terminal flags the last allowed wait cycle.
module apb_wait_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (inc) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign terminal = (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester for two slaves on a shared 8-bit bus.
// Optional ACCESS timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [REQ_ADDR_W-1:0] req_addr,
  input  logic [APB_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL1,
  output logic                  PSEL2,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_ADDR_W-1:0] PADDR,
  output logic [APB_DATA_W-1:0] PWDATA,
  input  logic [APB_DATA_W-1:0] PRDATA1,
  input  logic [APB_DATA_W-1:0] PRDATA2,
  input  logic                  PREADY1,
  input  logic                  PREADY2
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be in 2..255");
  end

  apb_state_e            state_q, state_d;
  logic                  slv_q, slv_d;
  logic                  pwrite_q, pwrite_d;
  logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  pready_sel;
  logic [APB_DATA_W-1:0] prdata_sel;
  logic                  timeout_hit;

  // The unselected slave's handshake is never looked at.
  assign pready_sel = (slv_q == SLV2) ? PREADY2 : PREADY1;
  assign prdata_sel = (slv_q == SLV2) ? PRDATA2 : PRDATA1;

`ifdef APB_TIMEOUT_EN
  logic timer_terminal;

  apb_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (PCLK),
    .rst     (PRESET),
    .clear   (state_q == SETUP),
    .inc     ((state_q == ACCESS) && !pready_sel),
    .terminal(timer_terminal)
  );

  assign timeout_hit = (state_q == ACCESS) && !pready_sel && timer_terminal;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      slv_q       <= SLV1;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      slv_q       <= slv_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_sel || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus fields load only on acceptance; the response pulses for exactly one cycle.
  always_comb begin
    slv_d       = slv_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    if (state_q == IDLE && req_valid) begin
      slv_d    = req_addr[REQ_ADDR_W-1];
      pwrite_d = req_write;
      paddr_d  = req_addr[APB_ADDR_W-1:0];
      pwdata_d = req_wdata;
    end
    if (state_q == ACCESS) begin
      if (pready_sel) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = pwrite_q ? '0 : prdata_sel;
      end else if (timeout_hit) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign PSEL1     = (state_q != IDLE) && (slv_q == SLV1);
  assign PSEL2     = (state_q != IDLE) && (slv_q == SLV2);
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed-vector bench for apb_master with two behavioural APB slave memories.
// Define APB_TIMEOUT_EN to also exercise the timeout abort path.
module tb_apb_master;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       req_valid, req_ready, req_write;
  logic [8:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA1, PRDATA2;
  logic       PREADY1, PREADY2;

  int n_vectors = 0;
  int n_miscompares = 0;

  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  int wait1 = 0, wait2 = 0;
  int acc1 = 0, acc2 = 0;

`ifdef APB_TIMEOUT_EN
  localparam int LONG_WAIT = 3;
`else
  localparam int LONG_WAIT = 4;
`endif

  typedef struct {
    logic       write;
    logic [8:0] addr;
    logic [7:0] wdata;
    int         wait_n;
    logic [7:0] exp_rdata;
    int         exp_lat;
    int         exp_en;
    logic       exp_err;
  } vec_t;

  apb_master #(.TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY1(PREADY1), .PREADY2(PREADY2)
  );

  always #5 PCLK = ~PCLK;

  // Slave models: PREADY stays low for waitN ACCESS cycles, writes commit on the completing edge.
  assign PREADY1 = (acc1 >= wait1);
  assign PREADY2 = (acc2 >= wait2);
  assign PRDATA1 = mem1[PADDR];
  assign PRDATA2 = mem2[PADDR];

  always @(posedge PCLK) begin
    if (PSEL1 && PENABLE && !PREADY1) acc1 <= acc1 + 1;
    else if (!PENABLE) acc1 <= 0;
    if (PSEL2 && PENABLE && !PREADY2) acc2 <= acc2 + 1;
    else if (!PENABLE) acc2 <= 0;
    if (PSEL1 && PENABLE && PREADY1 && PWRITE) mem1[PADDR] <= PWDATA;
    if (PSEL2 && PENABLE && PREADY2 && PWRITE) mem2[PADDR] <= PWDATA;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_sel_en"}, {PSEL1, PSEL2, PENABLE, PWRITE}, 4'b0000);
    checkOutput({tag, "_paddr"}, PADDR, 8'h00);
    checkOutput({tag, "_pwdata"}, PWDATA, 8'h00);
    checkOutput({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_rdata}, 10'h000);
    checkOutput({tag, "_ready"}, req_ready, 1'b1);
  endtask

  // Starts a transfer in the current cycle and follows it to the response.
  task automatic applyStimulus(input vec_t v);
    int cycles;
    int en;
    logic stable_ok;
    wait1 = v.wait_n;
    wait2 = v.wait_n;
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    checkOutput("accept_ready", req_ready, 1'b1);
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    cycles = 1;
    en = 0;
    stable_ok = 1'b1;
    checkOutput("setup_penable", PENABLE, 1'b0);
    checkOutput("setup_psel", {PSEL1, PSEL2}, {~v.addr[8], v.addr[8]});
    checkOutput("rsp_pulse", rsp_valid, 1'b0);
    while (!rsp_valid && cycles < 40) begin
      if (PENABLE) en++;
      if (PSEL1 !== ~v.addr[8] || PSEL2 !== v.addr[8] || PADDR !== v.addr[7:0] ||
          PWRITE !== v.write || PWDATA !== v.wdata || req_ready !== 1'b0)
        stable_ok = 1'b0;
      @(posedge PCLK); #1;
      cycles++;
    end
    checkOutput("latency", cycles, v.exp_lat);
    checkOutput("enable_cycles", en, v.exp_en);
    checkOutput("bus_stable", stable_ok, 1'b1);
    checkOutput("rsp_rdata", rsp_rdata, v.exp_rdata);
    checkOutput("rsp_err", rsp_err, v.exp_err);
    checkOutput("idle_sel_en", {PSEL1, PSEL2, PENABLE}, 3'b000);
    checkOutput("idle_ready", req_ready, 1'b1);
    checkOutput("idle_paddr_hold", PADDR, v.addr[7:0]);
  endtask

  initial begin
    vec_t vecs[9];
    vec_t v;

    for (int i = 0; i < 256; i++) begin
      mem1[i] = 8'(i) ^ 8'h5A;
      mem2[i] = 8'(i) ^ 8'hC3;
    end

    vecs[0] = '{1'b1, 9'h1A5, 8'h3C, 0, 8'h00, 3, 1, 1'b0};
    vecs[1] = '{1'b0, 9'h1A5, 8'h00, 0, 8'h3C, 3, 1, 1'b0};
    vecs[2] = '{1'b1, 9'h055, 8'h11, 0, 8'h00, 3, 1, 1'b0};
    vecs[3] = '{1'b0, 9'h155, 8'h00, 0, 8'h96, 3, 1, 1'b0};
    vecs[4] = '{1'b0, 9'h055, 8'h00, 0, 8'h11, 3, 1, 1'b0};
    vecs[5] = '{1'b0, 9'h1A5, 8'h00, LONG_WAIT, 8'h3C, 3 + LONG_WAIT, 1 + LONG_WAIT, 1'b0};
    vecs[6] = '{1'b1, 9'h0FF, 8'hE7, 2, 8'h00, 5, 3, 1'b0};
    vecs[7] = '{1'b0, 9'h0FF, 8'h00, 1, 8'hE7, 4, 2, 1'b0};
    vecs[8] = '{1'b0, 9'h010, 8'h00, 0, 8'h4A, 3, 1, 1'b0};

    PRESET = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(posedge PCLK);
    #1;
    checkIdleZero("reset");
    PRESET = 1'b0;

    $display("[TB] applying %0d table vectors back-to-back", 9);
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

`ifdef APB_TIMEOUT_EN
    $display("[TB] timeout abort with PREADY held low");
    v = '{1'b0, 9'h1A5, 8'h00, 1000, 8'h00, 6, 4, 1'b1};
    applyStimulus(v);
    v = '{1'b0, 9'h1A5, 8'h00, 0, 8'h3C, 3, 1, 1'b0};
    applyStimulus(v);
`endif

    $display("[TB] reset during a waited read");
    wait1 = 20;
    wait2 = 20;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 9'h1A5;
    req_wdata = 8'h00;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    checkOutput("pre_reset_access", {PSEL2, PENABLE}, 2'b11);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    checkIdleZero("midreset");
    @(posedge PCLK); #1;
    checkOutput("midreset_no_rsp", rsp_valid, 1'b0);
    PRESET = 1'b0;
    v = '{1'b0, 9'h1A5, 8'h00, 0, 8'h3C, 3, 1, 1'b0};
    applyStimulus(v);
    v = '{1'b1, 9'h0A0, 8'h5D, 1, 8'h00, 4, 2, 1'b0};
    applyStimulus(v);
    v = '{1'b0, 9'h0A0, 8'h00, 0, 8'h5D, 3, 1, 1'b0};
    applyStimulus(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

APB requester that sits directly upstream of the APB slave memories (slave1, slave2) on the shared 8-bit APB bus. It accepts one transfer at a time on a simple valid/ready request port and decodes a 9-bit request address into the two slave selects. It drives the SETUP/ACCESS phases, muxes the selected slave's PRDATA/PREADY, and returns a one-cycle response with the read data.

## Interface
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles with PREADY low before abort (used only with APB_TIMEOUT_EN); legal range 2..255
- PCLK  input  1  bus clock; all logic on rising edge
- PRESET  input  1  synchronous, active-high reset
- req_valid  input  1  transfer request present
- req_ready  output  1  master can accept a request this cycle
- req_write  input  1  1 = write, 0 = read
- req_addr  input  9  bit 8 = slave select (0 → slave1, 1 → slave2); bits 7:0 → PADDR
- req_wdata  input  8  write data
- rsp_valid  output  1  one-cycle pulse: transfer finished
- rsp_rdata  output  8  read data; 0 for writes and aborted transfers
- rsp_err  output  1  transfer aborted by timeout; qualified by rsp_valid
- PSEL1  output  1  select for slave1
- PSEL2  output  1  select for slave2
- PENABLE  output  1  APB enable
- PWRITE  output  1  APB direction
- PADDR  output  8  APB address
- PWDATA  output  8  APB write data
- PRDATA1  input  8  slave1 read data
- PRDATA2  input  8  slave2 read data
- PREADY1  input  1  slave1 ready
- PREADY2  input  1  slave2 ready

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch req_write/req_addr/req_wdata into PWRITE/PADDR/PWDATA and a registered slave index.
  - Go to SETUP.
- SETUP:
  - Selected PSELx = 1, PENABLE = 0, req_ready = 0.
  - Always go to ACCESS next cycle.
- ACCESS:
  - Selected PSELx = 1, PENABLE = 1.
  - PREADY_sel = PREADY1 or PREADY2 according to the latched index; the unselected slave's PREADY/PRDATA are ignored.
  - When PREADY_sel = 1: capture PRDATA_sel into rsp_rdata on a read, or 0 on a write. Register rsp_valid = 1, rsp_err = 0, and go to IDLE.
  - When PREADY_sel = 0: stay in ACCESS with all bus outputs held.
- Exactly one PSELx is high in SETUP/ACCESS; both are 0 in IDLE.
- PADDR, PWDATA and PWRITE are stable from SETUP through the last ACCESS cycle, and hold their last values in IDLE.
- No request queueing. A request presented while req_ready = 0 is not accepted and must be held by the requester.

## Timing
- Reset values: state IDLE; PSEL1/PSEL2/PENABLE/PWRITE = 0; PADDR/PWDATA = 0; rsp_valid/rsp_err = 0; rsp_rdata = 0; req_ready = 1 in the first cycle after reset.
- Zero-wait-state transfer:
  - Accept edge at cycle 0.
  - SETUP in cycle 1.
  - ACCESS in cycle 2.
  - rsp_valid in cycle 3, which is also IDLE with req_ready = 1.
- Back-to-back: a request may be accepted in the same cycle rsp_valid is high. Throughput is one transfer per 3 cycles.
- Each PREADY-low cycle in ACCESS adds one cycle of latency.
- PRESET asserted mid-transfer: at the next edge, return to IDLE and clear all outputs. No rsp_valid is issued for the aborted transfer.
- PRESET has priority over every other event.

## Configuration
- APB_TIMEOUT_EN defined:
  - A wait counter clears on entering ACCESS and increments on each ACCESS cycle with PREADY_sel = 0.
  - If PREADY_sel is still 0 when the count reaches TIMEOUT_CYCLES − 1, go to IDLE, drop PSELx/PENABLE, and pulse rsp_valid with rsp_err = 1 and rsp_rdata = 0.
  - PREADY_sel = 1 in the terminal cycle counts as a normal completion.
- APB_TIMEOUT_EN undefined:
  - No counter; ACCESS waits indefinitely.
  - rsp_err is tied to 0.
  - TIMEOUT_CYCLES is unused.

## Structure
- Shared package apb_pkg holds:
  - the state enum typedef (IDLE/SETUP/ACCESS);
  - APB_ADDR_W = 8, APB_DATA_W = 8, REQ_ADDR_W = 9;
  - slave index constants SLV1 = 0, SLV2 = 1.
- One sub-module, apb_wait_timer: the loadable wait counter with a terminal-count flag. It is instantiated only under APB_TIMEOUT_EN.

## Test plan
- Reset: hold PRESET for 3 cycles → all outputs 0, req_ready = 1.
- Write then read slave2:
  - Write req_addr = 0x1A5, wdata = 0x3C → PSEL2 high for 2 cycles, PADDR = 0xA5, PWRITE = 1, rsp_valid at cycle 3 with rsp_rdata = 0.
  - Read 0x1A5 → rsp_rdata = 0x3C.
- Slave isolation: write 0x055 = 0x11 to slave1, then read 0x155 → PSEL1 only during the write, and slave2 returns its own contents (not 0x11).
- Wait states: slave model holds PREADY2 low for 4 ACCESS cycles → PENABLE is high for 5 cycles, bus signals stay stable, and rsp_valid comes 4 cycles later than with zero waits.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES = 4): PREADY never asserted → abort after 4 ACCESS cycles, rsp_err = 1, rsp_rdata = 0, next request accepted normally.
- Reset mid-ACCESS: assert PRESET during a waited read → next cycle all outputs 0 and no rsp_valid; a back-to-back request after release completes normally.
